// File: rtl/core_pkg.sv
// Shared types for the 3-stage core's hazard control.
// Contents:
//   IDX_W      - register index width (16 GPRs)
//   wtag_t     - destination tag carried by stages 2 and 3 (index, write, load)
//   hz_state_e - hazard controller FSM states
package core_pkg;

    localparam int unsigned IDX_W = 4;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             write;
        logic             load;
    } wtag_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/stage_tag_reg.sv
// One pipeline stage's destination tag register.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   hold_i    - keep the current tag
//   clr_i     - load an empty tag (wins over hold_i)
//   d_i       - tag to take when neither hold nor clear
//   q_o       - registered tag
module stage_tag_reg
    import core_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  hold_i,
    input  logic  clr_i,
    input  wtag_t d_i,
    output wtag_t q_o
);

    wtag_t tag_q;

    // Clear beats hold so a stage can be emptied while the pipe is frozen.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q <= '0;
        end else if (clr_i) begin
            tag_q <= '0;
        end else if (!hold_i) begin
            tag_q <= d_i;
        end
    end

    assign q_o = tag_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and write-tag controller for the 3-stage core.
// Owns the stage-2/3 destination tags consumed by forwarding, inserts a
// one-cycle bubble on load-use, and freezes the pipe while a stage-3 load
// waits for memory, going to a sticky error after TIMEOUT blocked cycles.
// Ports:
//   clk, rst                          - clock, synchronous active-high reset
//   id_*                              - stage-1 instruction attributes
//   RegReadIndex11/21                 - stage-1 source indices
//   flush                             - branch taken in stage 2
//   mem_ready                         - stage-3 load data valid
//   RegWriteIndex2/3, RegWrite2/3     - registered stage-2/3 destination tags
//   Stall, Bubble                     - combinational pipe controls
//   mem_err                           - sticky memory timeout
//   stall_count                       - saturating count of stalled cycles
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned IDX_W   = core_pkg::IDX_W,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic             id_reg_write,
    input  logic             id_is_load,
    input  logic [IDX_W-1:0] id_write_index,
    input  logic             id_uses1,
    input  logic             id_uses2,
    input  logic [IDX_W-1:0] RegReadIndex11,
    input  logic [IDX_W-1:0] RegReadIndex21,
    input  logic             flush,
    input  logic             mem_ready,
    output logic [IDX_W-1:0] RegWriteIndex2,
    output logic [IDX_W-1:0] RegWriteIndex3,
    output logic             RegWrite2,
    output logic             RegWrite3,
    output logic             Stall,
    output logic             Bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    wtag_t            s2_q;
    wtag_t            s3_q;
    wtag_t            s2_d;
    hz_state_e        state_q;
    logic [WAIT_W-1:0] wait_q;
    logic             err_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic             load_use_c;
    logic             mem_block_c;
    logic [WAIT_W-1:0] wait_inc_c;
    logic             timeout_c;
    logic             stall_c;
    logic             bubble_c;
    logic             s2_hold_c;
    logic             s2_clr_c;
    logic             s3_hold_c;
    logic             s3_clr_c;

    // Hazard detection and per-stage tag controls, highest priority first.
    always_comb begin
        stall_c   = 1'b0;
        bubble_c  = 1'b0;
        s2_hold_c = 1'b0;
        s2_clr_c  = 1'b0;
        s3_hold_c = 1'b0;
        s3_clr_c  = 1'b0;

        load_use_c = s2_q.write & s2_q.load & id_valid &
                     ((id_uses1 & (RegReadIndex11 == s2_q.idx)) |
                      (id_uses2 & (RegReadIndex21 == s2_q.idx)));
        mem_block_c = (state_q != ERR) & s3_q.write & s3_q.load & ~mem_ready;

        // First blocked cycle counts as 1; later ones build on the stored count.
        wait_inc_c = (state_q == MEM_WAIT) ? WAIT_W'(wait_q + WAIT_W'(1)) : WAIT_W'(1);
        timeout_c  = mem_block_c & (wait_inc_c == WAIT_W'(TIMEOUT));

        s2_d.idx   = id_write_index;
        s2_d.write = id_valid & id_reg_write;
        s2_d.load  = id_valid & id_is_load;

        if (state_q == ERR) begin
            stall_c   = 1'b1;
            s2_hold_c = 1'b1;
            s3_hold_c = 1'b1;
        end else if (mem_block_c) begin
            // Branch in stage 2 is frozen too, so it re-asserts flush later.
            stall_c   = 1'b1;
            s2_hold_c = 1'b1;
            s3_hold_c = 1'b1;
            s3_clr_c  = timeout_c;
        end else if (flush) begin
            bubble_c = 1'b1;
            s2_clr_c = 1'b1;
        end else if (load_use_c) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
            s2_clr_c = 1'b1;
        end
    end

    // FSM, wait counter, sticky error and stall statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (stall_c && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state_q)
                RUN, MEM_WAIT: begin
                    if (mem_block_c) begin
                        if (timeout_c) begin
                            state_q <= ERR;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= MEM_WAIT;
                            wait_q  <= wait_inc_c;
                        end
                    end else begin
                        state_q <= RUN;
                        wait_q  <= '0;
                    end
                end
                ERR:     state_q <= ERR;
                default: state_q <= RUN;
            endcase
        end
    end

    stage_tag_reg u_stage2 (
        .clk    (clk),
        .rst    (rst),
        .hold_i (s2_hold_c),
        .clr_i  (s2_clr_c),
        .d_i    (s2_d),
        .q_o    (s2_q)
    );

    stage_tag_reg u_stage3 (
        .clk    (clk),
        .rst    (rst),
        .hold_i (s3_hold_c),
        .clr_i  (s3_clr_c),
        .d_i    (s2_q),
        .q_o    (s3_q)
    );

    assign RegWriteIndex2 = s2_q.idx;
    assign RegWrite2      = s2_q.write;
    assign RegWriteIndex3 = s3_q.idx;
    assign RegWrite3      = s3_q.write;
    // Reset forces the pipe controls low even from ERR.
    assign Stall          = stall_c & ~rst;
    assign Bubble         = bubble_c & ~rst;
    assign mem_err        = err_q;
    assign stall_count    = stall_cnt_q;

endmodule
